audio_stream_aligner: RTL and testbench

- Parametrised successor to the fixed left/right 24-bit audio controller streaming interface.
- Accepts NUM_CH independent Avalon-ST audio sample streams, each DATA_W bits wide, and buffers each stream in its own FIFO.
- Emits one time-aligned multichannel frame only when every channel has a sample available.
- Sits between the audio controller sink/source channels and the reverb datapath; flags inter-channel skew.

---
 rtl/audio_stream_aligner.sv | 167 ++++++++++++++++
 tb/tb_audio_stream_aligner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_stream_aligner.sv
// audio_stream_aligner: buffers NUM_CH independent Avalon-ST sample streams in
// per-channel FIFOs and emits one time-aligned multichannel frame whenever every
// channel holds at least one sample. Reports inter-channel fill skew and a sticky
// desync error when one channel is full while another is empty.
// Optional build macro AUDIO_ALIGN_MUTE_EN adds a mute_mask input that zeroes
// selected channels in the captured frame without changing FIFO timing.
module audio_stream_aligner #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk_clk,
    input  logic                               reset_reset_n,
    input  logic [NUM_CH*DATA_W-1:0]           sink_data,
    input  logic [NUM_CH-1:0]                  sink_valid,
    output logic [NUM_CH-1:0]                  sink_ready,
    output logic [NUM_CH*DATA_W-1:0]           source_data,
    output logic                               source_valid,
    input  logic                               source_ready,
`ifdef AUDIO_ALIGN_MUTE_EN
    input  logic [NUM_CH-1:0]                  mute_mask,
`endif
    input  logic                               clear,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    skew,
    output logic                               desync_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SKEW_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [NUM_CH-1:0][PTR_W-1:0] wr_ptr;
    logic [NUM_CH-1:0][PTR_W-1:0] rd_ptr;
    logic [NUM_CH-1:0][CNT_W-1:0] count;
    logic [DATA_W-1:0]            mem [NUM_CH][FIFO_DEPTH];

    logic [NUM_CH-1:0]            ch_ne;
    logic [NUM_CH-1:0]            ch_full;
    logic [NUM_CH-1:0]            wr_en;
    logic [NUM_CH-1:0]            mute_vec;
    logic                         all_ne;
    logic                         any_full;
    logic                         any_empty;
    logic                         load;
    logic [NUM_CH*DATA_W-1:0]     head_frame;
    logic [CNT_W-1:0]             cnt_max;
    logic [CNT_W-1:0]             cnt_min;
    logic [SKEW_W-1:0]            skew_next;

`ifdef AUDIO_ALIGN_MUTE_EN
    assign mute_vec = mute_mask;
`else
    assign mute_vec = '0;
`endif

    // Per-channel status from the registered counts only; ready never looks at valid,
    // so a full channel refuses data even when a frame pop frees a slot that cycle.
    always_comb begin
        ch_ne      = '0;
        ch_full    = '0;
        sink_ready = '0;
        wr_en      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            ch_ne[k]      = (count[k] != '0);
            ch_full[k]    = (count[k] == FULL_CNT);
            sink_ready[k] = !ch_full[k];
            wr_en[k]      = sink_valid[k] & !ch_full[k] & !clear;
        end
    end

    assign all_ne    = &ch_ne;
    assign any_full  = |ch_full;
    assign any_empty = ~&ch_ne;
    assign load      = all_ne & (!source_valid | source_ready) & !clear;

    // Gather the head sample of every channel, substituting zero for muted channels.
    always_comb begin
        head_frame = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            head_frame[k*DATA_W +: DATA_W] = mute_vec[k] ? '0 : mem[k][rd_ptr[k]];
        end
    end

    // Spread between the fullest and emptiest channel.
    always_comb begin
        cnt_max = '0;
        cnt_min = FULL_CNT;
        for (int k = 0; k < NUM_CH; k++) begin
            if (count[k] > cnt_max) begin
                cnt_max = count[k];
            end
            if (count[k] < cnt_min) begin
                cnt_min = count[k];
            end
        end
        skew_next = SKEW_W'(cnt_max - cnt_min);
    end

    // Sample storage; contents need no reset because pointers and counts gate every read.
    always_ff @(posedge clk_clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (wr_en[k]) begin
                mem[k][wr_ptr[k]] <= sink_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // FIFO pointers and fill counts; a frame pop reads every channel at once.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_en[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
                end
                if (load) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_W'(1);
                end
                if (wr_en[k] && !load) begin
                    count[k] <= count[k] + CNT_W'(1);
                end else if (!wr_en[k] && load) begin
                    count[k] <= count[k] - CNT_W'(1);
                end
            end
        end
    end

    // Output frame register; data is held while stalled and after the frame is taken.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            source_valid <= 1'b0;
            source_data  <= '0;
        end else if (clear) begin
            source_valid <= 1'b0;
        end else if (load) begin
            source_valid <= 1'b1;
            source_data  <= head_frame;
        end else if (source_valid && source_ready) begin
            source_valid <= 1'b0;
        end
    end

    // Skew tracks the registered counts; desync latches until clear or reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            skew       <= '0;
            desync_err <= 1'b0;
        end else if (clear) begin
            skew       <= '0;
            desync_err <= 1'b0;
        end else begin
            skew <= skew_next;
            if (any_full && any_empty) begin
                desync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_stream_aligner.sv
// Directed testbench for audio_stream_aligner (NUM_CH=2, DATA_W=24, FIFO_DEPTH=8).
// A table of single-cycle vectors covers first-frame latency, handshake and
// clear collisions; hand-written sequences cover throughput, backpressure,
// desync and reset in the middle of a frame.
module tb_audio_stream_aligner;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 24;
    localparam int FIFO_DEPTH = 8;
    localparam int SKEW_W     = 4;

    logic                      clk_clk = 1'b0;
    logic                      reset_reset_n = 1'b0;
    logic [NUM_CH*DATA_W-1:0]  sink_data = '0;
    logic [NUM_CH-1:0]         sink_valid = '0;
    logic [NUM_CH-1:0]         sink_ready;
    logic [NUM_CH*DATA_W-1:0]  source_data;
    logic                      source_valid;
    logic                      source_ready = 1'b0;
    logic                      clear = 1'b0;
    logic [SKEW_W-1:0]         skew;
    logic                      desync_err;
`ifdef AUDIO_ALIGN_MUTE_EN
    logic [NUM_CH-1:0]         mute_mask = '0;
`endif

    int compared   = 0;
    int mismatched = 0;

    localparam logic [47:0] FRAME_A = {24'hABCDEF, 24'h123456};
`ifdef AUDIO_ALIGN_MUTE_EN
    localparam logic [47:0] FRAME_B = {24'h000000, 24'h000222};
`else
    localparam logic [47:0] FRAME_B = {24'h000111, 24'h000222};
`endif

    typedef struct {
        logic [1:0]  sv;
        logic [23:0] d0;
        logic [23:0] d1;
        logic        sr;
        logic        clr;
        logic [1:0]  mute;
        logic [1:0]  exp_rdy;
        logic        exp_vld;
        logic [47:0] exp_data;
    } vec_t;

    vec_t vecs [13];

    audio_stream_aligner #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .sink_data     (sink_data),
        .sink_valid    (sink_valid),
        .sink_ready    (sink_ready),
        .source_data   (source_data),
        .source_valid  (source_valid),
        .source_ready  (source_ready),
`ifdef AUDIO_ALIGN_MUTE_EN
        .mute_mask     (mute_mask),
`endif
        .clear         (clear),
        .skew          (skew),
        .desync_err    (desync_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk_clk = ~clk_clk;

    // Hard stop in case a sequence never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [1:0] sv, input logic [23:0] d0, input logic [23:0] d1,
                                input logic sr, input logic clr, input logic [1:0] mute,
                                input logic [1:0] exp_rdy, input logic exp_vld, input logic [47:0] exp_data);
        vec_t v;
        v.sv = sv; v.d0 = d0; v.d1 = d1; v.sr = sr; v.clr = clr; v.mute = mute;
        v.exp_rdy = exp_rdy; v.exp_vld = exp_vld; v.exp_data = exp_data;
        return v;
    endfunction

    function automatic logic [47:0] tput_frame(input int i);
        return {24'h200000 | 24'(i), 24'h100000 | 24'(i)};
    endfunction

    function automatic logic [47:0] bp_frame(input int i);
        return {24'h400000 | 24'(i), 24'h300000 | 24'(i)};
    endfunction

    task automatic applyStimulus(input vec_t v);
        sink_valid   = v.sv;
        sink_data    = {v.d1, v.d0};
        source_ready = v.sr;
        clear        = v.clr;
`ifdef AUDIO_ALIGN_MUTE_EN
        mute_mask    = v.mute;
`endif
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic set_idle();
        sink_valid   = '0;
        sink_data    = '0;
        source_ready = 1'b1;
        clear        = 1'b0;
`ifdef AUDIO_ALIGN_MUTE_EN
        mute_mask    = '0;
`endif
    endtask

    task automatic pulse_clear();
        set_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        int first_cyc;
        int last_cyc;
        int nvalid;
        int idx;

        vecs[0]  = mk(2'b01, 24'h123456, 24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 48'h0);
        vecs[1]  = mk(2'b00, 24'h0,      24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 48'h0);
        vecs[2]  = mk(2'b10, 24'h0,      24'hABCDEF, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, 48'h0);
        vecs[3]  = mk(2'b00, 24'h0,      24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b1, FRAME_A);
        vecs[4]  = mk(2'b11, 24'h000222, 24'h000111, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_A);
        vecs[5]  = mk(2'b00, 24'h0,      24'h0,      1'b0, 1'b0, 2'b10, 2'b11, 1'b1, FRAME_B);
        vecs[6]  = mk(2'b00, 24'h0,      24'h0,      1'b0, 1'b0, 2'b00, 2'b11, 1'b1, FRAME_B);
        vecs[7]  = mk(2'b00, 24'h0,      24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_B);
        vecs[8]  = mk(2'b01, 24'h0000AA, 24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_B);
        vecs[9]  = mk(2'b10, 24'h0,      24'h0000BB, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_B);
        vecs[10] = mk(2'b11, 24'h0000CC, 24'h0000DD, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, FRAME_B);
        vecs[11] = mk(2'b00, 24'h0,      24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_B);
        vecs[12] = mk(2'b00, 24'h0,      24'h0,      1'b1, 1'b0, 2'b00, 2'b11, 1'b0, FRAME_B);

        // Reset values while reset is held.
        repeat (2) @(posedge clk_clk);
        #1;
        checkOutput("rst_sink_ready",   64'(sink_ready),   64'h3);
        checkOutput("rst_source_valid", 64'(source_valid), 64'h0);
        checkOutput("rst_source_data",  64'(source_data),  64'h0);
        checkOutput("rst_skew",         64'(skew),         64'h0);
        checkOutput("rst_desync",       64'(desync_err),   64'h0);
        #2;
        reset_reset_n = 1'b1;

        // Table: latency, handshake, mute/pass-through, clear collision.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d_sink_ready", i), 64'(sink_ready),   64'(vecs[i].exp_rdy));
            checkOutput($sformatf("vec%0d_valid", i),      64'(source_valid), 64'(vecs[i].exp_vld));
            checkOutput($sformatf("vec%0d_data", i),       64'(source_data),  64'(vecs[i].exp_data));
        end

        // Throughput: 100 frames at one per clock, in order, skew stays 0.
        pulse_clear();
        first_cyc = -1;
        last_cyc  = -1;
        nvalid    = 0;
        for (int cyc = 0; cyc < 110; cyc++) begin
            sink_valid   = (cyc < 100) ? 2'b11 : 2'b00;
            sink_data    = tput_frame(cyc);
            source_ready = 1'b1;
            tick();
            checkOutput("tput_skew", 64'(skew), 64'h0);
            if (source_valid) begin
                checkOutput("tput_data", 64'(source_data), 64'(tput_frame(nvalid)));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                nvalid++;
            end
        end
        checkOutput("tput_frames", 64'(nvalid), 64'd100);
        checkOutput("tput_first",  64'(first_cyc), 64'd1);
        checkOutput("tput_span",   64'(last_cyc - first_cyc + 1), 64'd100);

        // Backpressure: fill both FIFOs behind a stalled output register.
        pulse_clear();
        for (int w = 0; w < 9; w++) begin
            sink_valid   = 2'b11;
            sink_data    = bp_frame(w);
            source_ready = 1'b0;
            tick();
            if (w >= 1) begin
                checkOutput("bp_hold_valid", 64'(source_valid), 64'h1);
                checkOutput("bp_hold_data",  64'(source_data),  64'(bp_frame(0)));
            end
        end
        sink_valid = 2'b00;
        checkOutput("bp_full_ready", 64'(sink_ready), 64'h0);
        tick();
        tick();
        checkOutput("bp_full_skew",   64'(skew),       64'h0);
        checkOutput("bp_full_desync", 64'(desync_err), 64'h0);
        checkOutput("bp_still_data",  64'(source_data), 64'(bp_frame(0)));
        idx = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            source_ready = 1'b1;
            if (source_valid) begin
                checkOutput("bp_drain_data", 64'(source_data), 64'(bp_frame(idx)));
                idx++;
            end
            tick();
        end
        checkOutput("bp_drain_count", 64'(idx), 64'd9);
        checkOutput("bp_drain_valid", 64'(source_valid), 64'h0);

        // Desync: only channel 0 written until full.
        pulse_clear();
        for (int i = 0; i < 8; i++) begin
            sink_valid = 2'b01;
            sink_data  = {24'h0, 24'h500000 | 24'(i)};
            tick();
        end
        sink_valid = 2'b00;
        tick();
        tick();
        checkOutput("desync_ready", 64'(sink_ready),   64'h2);
        checkOutput("desync_skew",  64'(skew),         64'd8);
        checkOutput("desync_flag",  64'(desync_err),   64'h1);
        checkOutput("desync_valid", 64'(source_valid), 64'h0);
        sink_valid = 2'b10;
        sink_data  = {24'h600000, 24'h0};
        tick();
        sink_valid = 2'b00;
        tick();
        checkOutput("desync_frame_valid", 64'(source_valid), 64'h1);
        checkOutput("desync_frame_data",  64'(source_data),  64'({24'h600000, 24'h500000}));
        tick();
        checkOutput("desync_sticky",      64'(desync_err),   64'h1);
        checkOutput("desync_after_valid", 64'(source_valid), 64'h0);
        pulse_clear();
        checkOutput("clr_valid",  64'(source_valid), 64'h0);
        checkOutput("clr_desync", 64'(desync_err),   64'h0);
        checkOutput("clr_skew",   64'(skew),         64'h0);
        checkOutput("clr_ready",  64'(sink_ready),   64'h3);
        tick();
        checkOutput("clr_skew_settled", 64'(skew), 64'h0);

        // Reset mid-frame: the buffered channel-0 sample must be discarded.
        set_idle();
        sink_valid = 2'b01;
        sink_data  = {24'h0, 24'h000055};
        tick();
        sink_valid    = 2'b00;
        reset_reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(source_valid), 64'h0);
        checkOutput("midrst_ready", 64'(sink_ready),   64'h3);
        #2;
        reset_reset_n = 1'b1;
        sink_valid = 2'b10;
        sink_data  = {24'h000066, 24'h0};
        tick();
        sink_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("midrst_no_frame", 64'(source_valid), 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
